// File: rtl/array_bank_rsp.sv
`default_nettype none
// ============================================================================
// Module      : array_bank_rsp
// Description : Responder-side timing and protocol monitor for one array bank.
//               It tracks row activations and flags tRAS, tRP, row-change and
//               (when ARRAY_RSP_SEQCHK_EN is defined) row-sequence errors.
// Revision    : 1.0 - initial release
// ============================================================================
module array_bank_rsp #(
    parameter int unsigned                ADDR_ROW_WIDTH = 14,
    parameter logic [ADDR_ROW_WIDTH-1:0]  MAX_ROW_ADDR   = 14'h3fff
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      array_banksel_n,
    input  logic [ADDR_ROW_WIDTH-1:0] array_raddr,
    input  logic [7:0]                array_tras_cfg,
    input  logic [7:0]                array_trp_cfg,
    input  logic                      err_clr,
    output logic                      act_vld,
    output logic [ADDR_ROW_WIDTH-1:0] act_row,
    output logic                      row_busy,
    output logic                      tras_err,
    output logic                      trp_err,
    output logic                      row_chg_err,
    output logic                      seq_err,
    output logic                      sweep_done
);

    typedef enum logic [0:0] {
        ST_PRE = 1'b0,
        ST_ACT = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic                      prev_q;
    logic [7:0]                low_cnt_q, low_cnt_d;
    logic [7:0]                high_cnt_q, high_cnt_d;
    logic [ADDR_ROW_WIDTH-1:0] act_row_q, act_row_d;
    logic                      act_vld_q, act_vld_d;
    logic                      row_busy_q, row_busy_d;
    logic                      sweep_q, sweep_d;
    logic                      tras_err_q, trp_err_q, chg_err_q;
    logic                      tras_set, trp_set, chg_set;

    logic w_fall;
    logic w_rise;

    assign w_fall = prev_q & ~array_banksel_n;
    assign w_rise = ~prev_q & array_banksel_n;

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == 8'hff) ? cnt : cnt + 8'd1;
    endfunction

    always_comb begin
        state_d    = state_q;
        low_cnt_d  = low_cnt_q;
        high_cnt_d = high_cnt_q;
        act_row_d  = act_row_q;
        act_vld_d  = 1'b0;
        row_busy_d = row_busy_q;
        sweep_d    = 1'b0;
        tras_set   = 1'b0;
        trp_set    = 1'b0;
        chg_set    = 1'b0;
        case (state_q)
            ST_PRE: begin
                if (w_fall) begin
                    state_d    = ST_ACT;
                    act_row_d  = array_raddr;
                    act_vld_d  = 1'b1;
                    row_busy_d = 1'b1;
                    low_cnt_d  = 8'd1;
                    trp_set    = (high_cnt_q < array_trp_cfg);
                end else if (array_banksel_n) begin
                    high_cnt_d = sat_inc(high_cnt_q);
                end
            end
            ST_ACT: begin
                // The row is latched on entry, so any cycle spent here compares
                chg_set = (array_raddr != act_row_q);
                if (w_rise) begin
                    state_d    = ST_PRE;
                    row_busy_d = 1'b0;
                    high_cnt_d = 8'd1;
                    tras_set   = (low_cnt_q < array_tras_cfg);
                    sweep_d    = (act_row_q == MAX_ROW_ADDR);
                end else if (!array_banksel_n) begin
                    low_cnt_d = sat_inc(low_cnt_q);
                end
            end
            default: state_d = ST_PRE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_PRE;
            prev_q     <= 1'b1;
            low_cnt_q  <= 8'd0;
            high_cnt_q <= 8'hff;
            act_row_q  <= '0;
            act_vld_q  <= 1'b0;
            row_busy_q <= 1'b0;
            sweep_q    <= 1'b0;
            tras_err_q <= 1'b0;
            trp_err_q  <= 1'b0;
            chg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= array_banksel_n;
            low_cnt_q  <= low_cnt_d;
            high_cnt_q <= high_cnt_d;
            act_row_q  <= act_row_d;
            act_vld_q  <= act_vld_d;
            row_busy_q <= row_busy_d;
            sweep_q    <= sweep_d;
            // A new error wins over a simultaneous clear
            tras_err_q <= tras_set | (tras_err_q & ~err_clr);
            trp_err_q  <= trp_set  | (trp_err_q  & ~err_clr);
            chg_err_q  <= chg_set  | (chg_err_q  & ~err_clr);
        end
    end

`ifdef ARRAY_RSP_SEQCHK_EN
    logic [ADDR_ROW_WIDTH-1:0] exp_row_q, exp_row_d;
    logic                      seq_err_q, seq_set;

    always_comb begin
        exp_row_d = exp_row_q;
        seq_set   = 1'b0;
        if (state_q == ST_PRE && w_fall) begin
            seq_set   = (array_raddr != exp_row_q);
            exp_row_d = (array_raddr == MAX_ROW_ADDR) ? '0 : array_raddr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_row_q <= '0;
            seq_err_q <= 1'b0;
        end else begin
            exp_row_q <= exp_row_d;
            seq_err_q <= seq_set | (seq_err_q & ~err_clr);
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

    assign act_vld     = act_vld_q;
    assign act_row     = act_row_q;
    assign row_busy    = row_busy_q;
    assign tras_err    = tras_err_q;
    assign trp_err     = trp_err_q;
    assign row_chg_err = chg_err_q;
    assign sweep_done  = sweep_q;

endmodule
`default_nettype wire
